// File: rtl/e203_thread_sched.sv
// ---------------------------------------------------------------------------
// e203_thread_sched
//
// Fine-grained hardware thread scheduler for the multithreaded E203 core.
// Produces the one-hot thread_sel vector that steers the replicated per-thread
// CSR files and commit enables. Execution rotates among runnable threads on a
// retired-instruction quantum. Threads park on WFI and wake on interrupt.
// Every switch drains the pipeline first, so thread_sel never changes while
// instructions are in flight.
//
// Ports:
//   clk             core clock
//   rst_n           asynchronous active-low reset
//   thread_en       software enable mask, one bit per thread
//   thread_irq      per-thread pending and enabled interrupt (level)
//   cmt_instret_ena selected thread retired an instruction this cycle
//   cmt_wfi_ena     selected thread committed WFI this cycle
//   dbg_mode        debug mode, inhibits new switches
//   sw_ack          pipeline drained, only looked at while draining
//   sw_req          hold-and-drain request to the pipeline (IFU halt)
//   thread_sel      one-hot current thread
//   thread_sleep    per-thread WFI sleep flags
//   core_idle       no runnable thread exists
// ---------------------------------------------------------------------------
module e203_thread_sched #(
  parameter int THREADS_NUM = 2,  // E203_THREADS_NUM
  parameter int QUANTUM     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [THREADS_NUM-1:0] thread_en,
  input  logic [THREADS_NUM-1:0] thread_irq,
  input  logic                   cmt_instret_ena,
  input  logic                   cmt_wfi_ena,
  input  logic                   dbg_mode,
  input  logic                   sw_ack,
  output logic                   sw_req,
  output logic [THREADS_NUM-1:0] thread_sel,
  output logic [THREADS_NUM-1:0] thread_sleep,
  output logic                   core_idle
);

  localparam int IW = (THREADS_NUM > 1) ? $clog2(THREADS_NUM) : 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_IDLE   = 2'd3;

  logic [1:0]             state_reg,      state_next;
  logic [THREADS_NUM-1:0] sel_reg,        sel_next;
  logic [THREADS_NUM-1:0] sleep_reg,      sleep_next;
  logic [THREADS_NUM-1:0] runnable_q_reg;
  logic [7:0]             cnt_reg,        cnt_next;
  logic                   sw_req_reg,     sw_req_next;
  logic                   idle_reg,       idle_next;

  logic [THREADS_NUM-1:0] runnable;
  logic [THREADS_NUM-1:0] others;
  logic [THREADS_NUM-1:0] irq_others;
  logic [THREADS_NUM-1:0] cand;
  logic [THREADS_NUM-1:0] target;
  logic                   cur_irq;
  logic                   cur_en;
  logic                   expire;
  logic                   want_switch;

  // Round-robin search starting just after the current thread and wrapping,
  // so the current thread is considered last. Interrupting threads win a
  // first pass; any candidate is accepted on the second pass.
  function automatic logic [THREADS_NUM-1:0] rr_pick(
    input logic [THREADS_NUM-1:0] c,
    input logic [THREADS_NUM-1:0] cur_oh,
    input logic [THREADS_NUM-1:0] irq
  );
    logic [THREADS_NUM-1:0] res;
    logic                   found;
    int                     cur_idx;
    int                     idx;
    res     = '0;
    found   = 1'b0;
    cur_idx = 0;
    for (int i = 0; i < THREADS_NUM; i++) begin
      if (cur_oh[i]) cur_idx = i;
    end
    for (int k = 1; k <= THREADS_NUM; k++) begin
      idx = cur_idx + k;
      if (idx >= THREADS_NUM) idx = idx - THREADS_NUM;
      if (!found && c[IW'(idx)] && irq[IW'(idx)]) begin
        res[IW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
    for (int k = 1; k <= THREADS_NUM; k++) begin
      idx = cur_idx + k;
      if (idx >= THREADS_NUM) idx = idx - THREADS_NUM;
      if (!found && c[IW'(idx)]) begin
        res[IW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
    return res;
  endfunction

  assign runnable   = thread_en & ~sleep_reg;
  assign others     = runnable & ~sel_reg;
  assign irq_others = others & thread_irq;
  assign cur_irq    = |(thread_irq & sel_reg);
  assign cur_en     = |(thread_en & sel_reg);
  assign expire     = cmt_instret_ena && (cnt_reg == 8'(QUANTUM - 1));

  assign want_switch = (expire && (|others)) || cmt_wfi_ena || !cur_en ||
                       ((|irq_others) && !cur_irq);

  // IDLE works from the registered runnable view: a wake-up that clears a
  // sleep flag at one edge is acted on two edges later.
  assign cand   = (state_reg == ST_IDLE) ? runnable_q_reg : runnable;
  assign target = rr_pick(cand, sel_reg, thread_irq);

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (!dbg_mode && want_switch) begin
          state_next = ST_DRAIN;
        end else if (!dbg_mode && cmt_instret_ena) begin
          // Quantum ran out with nobody else to run: start a fresh slice.
          cnt_next = expire ? 8'd0 : cnt_reg + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (sw_ack) begin
          if (|runnable) begin
            state_next = ST_SWITCH;
            sel_next   = target;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_SWITCH: begin
        state_next = ST_RUN;
        cnt_next   = 8'd0;
      end
      default: begin  // ST_IDLE
        if (|runnable_q_reg) begin
          state_next = ST_SWITCH;
          sel_next   = target;
        end
      end
    endcase
  end

  // An interrupt clearing a flag beats a WFI setting it in the same cycle.
  always_comb begin
    sleep_next = sleep_reg;
    if (state_reg == ST_RUN && cmt_wfi_ena) sleep_next = sleep_next | sel_reg;
    sleep_next = sleep_next & ~thread_irq;
  end

  assign sw_req_next = (state_next != ST_RUN);
  assign idle_next   = (state_next == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      sel_reg        <= THREADS_NUM'(1);
      sleep_reg      <= '0;
      runnable_q_reg <= '0;
      cnt_reg        <= 8'd0;
      sw_req_reg     <= 1'b0;
      idle_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      sleep_reg      <= sleep_next;
      runnable_q_reg <= runnable;
      cnt_reg        <= cnt_next;
      sw_req_reg     <= sw_req_next;
      idle_reg       <= idle_next;
    end
  end

  assign sw_req       = sw_req_reg;
  assign thread_sel   = sel_reg;
  assign thread_sleep = sleep_reg;
  assign core_idle    = idle_reg;

endmodule

// File: doc/e203_thread_sched.md
# e203_thread_sched

Fine-grained thread scheduler for the multithreaded E203 core. Generates the one-hot `thread_sel` vector that steers the replicated per-thread CSR files and commit enables. It rotates execution among enabled, non-sleeping threads on an instruction-count quantum, parks threads on WFI, and wakes them on interrupt. Every switch uses a drain handshake with the pipeline, so `thread_sel` never changes while instructions are outstanding.

## Interface
Parameters:
- `THREADS_NUM`, default `E203_THREADS_NUM` (2): number of hardware threads, range 2..8.
- `QUANTUM`, default 8: retired instructions per time slice, range 1..255.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `thread_en`  in  THREADS_NUM  software enable mask, one bit per thread.
- `thread_irq`  in  THREADS_NUM  per-thread pending and enabled interrupt (level).
- `cmt_instret_ena`  in  1  the selected thread retired an instruction this cycle.
- `cmt_wfi_ena`  in  1  the selected thread committed WFI this cycle.
- `dbg_mode`  in  1  debug mode; inhibits new switches.
- `sw_ack`  in  1  pipeline is drained (no outstanding instructions); sampled only in DRAIN.
- `sw_req`  out  1  hold-and-drain request to the pipeline (IFU halt).
- `thread_sel`  out  THREADS_NUM  one-hot current thread.
- `thread_sleep`  out  THREADS_NUM  per-thread WFI sleep flags.
- `core_idle`  out  1  no runnable thread exists.

## Operation
- A thread is runnable when `thread_en[i] & ~thread_sleep[i]`.
- Quantum counter: 8 bits. It increments on `cmt_instret_ena` in RUN while `dbg_mode` is 0, and is cleared on entry to RUN.
- Sleep flags:
  - `thread_sleep[cur]` sets on `cmt_wfi_ena` in RUN.
  - `thread_sleep[i]` clears when `thread_irq[i]` is 1.
  - If set and clear occur in the same cycle, clear wins.
- Target selection: a round-robin search starting at cur+1 and wrapping, with cur searched last.
  - First pass considers runnable threads with `thread_irq` set.
  - Second pass considers all runnable threads.
- States:
  - **RUN** (`sw_req`=0). Go to DRAIN when any of the following holds, and `dbg_mode` is 0:
    - (a) quantum expires, meaning `cmt_instret_ena` with cnt==QUANTUM-1, and another thread is runnable;
    - (b) `cmt_wfi_ena`;
    - (c) `thread_en[cur]`==0;
    - (d) another runnable thread has `thread_irq` set while the current thread has none.
  - If the quantum expires but no other thread is runnable, clear the counter and stay in RUN.
  - **DRAIN** (`sw_req`=1). On `sw_ack`: if any thread is runnable, latch the target and go to SWITCH; otherwise go to IDLE. A DRAIN already in progress completes even if `dbg_mode` rises.
  - **SWITCH** (`sw_req`=1, one cycle). `thread_sel` takes the target at entry. Then go to RUN.
  - **IDLE** (`sw_req`=1, `core_idle`=1). When any thread becomes runnable, latch the target and go to SWITCH.
- Reset values:
  - state RUN, `thread_sel`=1 (thread 0), counter 0;
  - `thread_sleep`=0, `sw_req`=0, `core_idle`=0.
- If `thread_en[0]`==0 out of reset, rule (c) moves the block to DRAIN on the first cycle.
- `thread_sel` is always exactly one-hot, including in IDLE, where it holds its last value. It changes only on entry to SWITCH.

## Timing
- All outputs are registered.
- `sw_req` rises in the cycle after the triggering commit.
- `thread_sel` changes in the cycle after `sw_ack` is sampled high in DRAIN.
- `sw_req` falls one cycle after that, on entry to RUN. The minimum switch penalty is 3 cycles: DRAIN, SWITCH, then the first RUN cycle.
- `sw_ack` outside DRAIN is ignored. `cmt_*` inputs are ignored outside RUN.
- IDLE exit: `thread_irq` high at edge N clears sleep at N. The runnable thread is seen at N+1 and SWITCH is entered at N+2.
- An asynchronous reset in any state returns all outputs to reset values immediately, with no handshake completion.

## Test plan
- Quantum rotation, 2 threads both enabled, QUANTUM=8, `sw_ack` tied high: 8 retires on thread 0 raise `sw_req`; `thread_sel` goes 01→10 two cycles later; rotation continues every 8 retires.
- Single enabled thread (`thread_en`=01): 20 retires give no `sw_req`, `thread_sel` stays 01, and the counter wraps at 8.
- WFI:
  - Thread 0 WFI with thread 1 runnable → switch to 10 and `thread_sleep`=01.
  - Then thread 1 WFI → IDLE with `core_idle`=1.
  - Then `thread_irq`=01 → `thread_sleep`=00 and `thread_sel`=01 two cycles later.
- Delayed ack: `sw_ack` held low 5 cycles in DRAIN → `sw_req` stays 1 and `thread_sel` is unchanged until the ack; `sw_ack` pulses in RUN have no effect.
- Debug: `dbg_mode`=1 with the quantum expiring and WFI committed → no DRAIN and the counter is frozen. Raising `dbg_mode` during DRAIN still completes the switch.
- Reset: `rst_n` asserted in SWITCH → `thread_sel`=01, `sw_req`=0, `thread_sleep`=00 with no clock edge needed.
